// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit-counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned DefaultCntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = serial_subtractor_pkg::DefaultWidth
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow, zero
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Pure combinational cell, mirror image of the full adder.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one bit per clock, LSB first.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned          CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0]      LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             bff_q, bff_d;
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (bff_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Result after shifting the current difference bit in at the MSB.
    assign res_next = {bit_d, res_sr_q[WIDTH-1:1]};

    // Next-state: FSM, datapath shifts and completion flag capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        bff_d    = bff_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    res_sr_d = '0;
                    bff_d    = 1'b0;
                    a_sign_d = bus.a[WIDTH-1];
                    b_sign_d = bus.b[WIDTH-1];
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_next;
                bff_d    = bit_bout;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    state_d  = StDone;
                    diff_d   = res_next;
                    borrow_d = bit_bout;
                    // Overflow only possible when operand signs differ.
                    ovf_d    = (a_sign_q != b_sign_q) && (res_next[WIDTH-1] != a_sign_q);
                    zero_d   = (res_next == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            bff_q    <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            bff_q    <= bff_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Status is a pure decode of the registered state.
    always_comb begin
        bus.busy     = (state_q == StRun);
        bus.done     = (state_q == StDone);
        bus.diff     = diff_q;
        bus.borrow   = borrow_q;
        bus.overflow = ovf_q;
        bus.zero     = zero_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Present operands with start for one accepting edge; returns on the following negedge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
    endtask

    // Count edges (from the current negedge) until done is seen; -1 on timeout.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && edges < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        if (bus.done !== 1'b1) edges = -1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.borrow, bus.overflow, bus.zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {bus.busy, bus.done, bus.diff, bus.borrow, bus.overflow, bus.zero});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_timing();
        int edges, busy_cnt;
        launch(8'h5A, 8'h3C, 1'b0);
        wait_done(edges, busy_cnt);
        checks++;
        if (edges !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges expected 8", edges);
        end
        checks++;
        if (busy_cnt !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d expected 8", busy_cnt);
        end
        checks++;
        if ({bus.diff, bus.borrow, bus.overflow, bus.zero} !== {8'h1E, 3'b000}) begin
            errors++;
            $display("FAIL basic_result: got diff=%h b=%b v=%b z=%b expected 1e 0 0 0",
                     bus.diff, bus.borrow, bus.overflow, bus.zero);
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00 || bus.diff !== 8'h1E) begin
            errors++;
            $display("FAIL basic_after_done: got done=%b busy=%b diff=%h expected 0 0 1e",
                     bus.done, bus.busy, bus.diff);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [4] = '{8'h10, 8'h80, 8'h7F, 8'h33};
        logic [W-1:0] vb [4] = '{8'h20, 8'h01, 8'hFF, 8'h33};
        logic [W-1:0] ed [4] = '{8'hF0, 8'h7F, 8'h80, 8'h00};
        logic [2:0]   ef [4] = '{3'b100, 3'b010, 3'b110, 3'b001}; // {borrow, ovf, zero}
        int edges, busy_cnt;
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i], 1'b0);
            wait_done(edges, busy_cnt);
            checks++;
            if (edges !== 8 || bus.diff !== ed[i] ||
                {bus.borrow, bus.overflow, bus.zero} !== ef[i]) begin
                errors++;
                $display("FAIL vector_%0d %h-%h: got edges=%0d diff=%h bvz=%b expected 8 %h %b",
                         i, va[i], vb[i], edges, bus.diff,
                         {bus.borrow, bus.overflow, bus.zero}, ed[i], ef[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int edges, busy_cnt;
        launch(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(edges, busy_cnt);
        checks++;
        if (edges !== 4 || bus.diff !== 8'h1E || bus.borrow !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: got edges=%0d diff=%h borrow=%b expected 4 1e 0",
                     edges, bus.diff, bus.borrow);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int edges, busy_cnt, seen_done;
        launch(8'h10, 8'h20, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.borrow, bus.overflow, bus.zero} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got %b expected all zero",
                     {bus.busy, bus.done, bus.diff, bus.borrow, bus.overflow, bus.zero});
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d active cycles expected 0", seen_done);
        end
        launch(8'h09, 8'h04, 1'b0);
        wait_done(edges, busy_cnt);
        checks++;
        if (edges !== 8 || bus.diff !== 8'h05 || {bus.borrow, bus.overflow, bus.zero} !== 3'b000) begin
            errors++;
            $display("FAIL after_reset_op: got edges=%0d diff=%h bvz=%b expected 8 05 000",
                     edges, bus.diff, {bus.borrow, bus.overflow, bus.zero});
        end
    endtask

    task automatic test_back_to_back();
        int edges, busy_cnt, mid_bad;
        launch(8'h80, 8'h01, 1'b1);
        bus.a = 8'h10;
        bus.b = 8'h20;
        wait_done(edges, busy_cnt);
        checks++;
        if (edges !== 8 || bus.diff !== 8'h7F || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got edges=%0d diff=%h ovf=%b expected 8 7f 1",
                     edges, bus.diff, bus.overflow);
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept_in_done: got busy=%b done=%b expected 1 0",
                     bus.busy, bus.done);
        end
        bus.start = 1'b0;
        mid_bad = 0;
        edges   = 0;
        while (bus.done !== 1'b1 && edges < 40) begin
            if (bus.diff !== 8'h7F) mid_bad++;
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        checks++;
        if (mid_bad !== 0) begin
            errors++;
            $display("FAIL b2b_diff_hold: got %0d cycles not 7f expected 0", mid_bad);
        end
        checks++;
        if (bus.done !== 1'b1 || edges + 1 !== 9) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d edges done=%b expected 9 1", edges + 1, bus.done);
        end
        checks++;
        if (bus.diff !== 8'hF0 || {bus.borrow, bus.overflow, bus.zero} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_second: got diff=%h bvz=%b expected f0 100",
                     bus.diff, {bus.borrow, bus.overflow, bus.zero});
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_vectors();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
